// File: rtl/core_router_pkg.sv
// Shared types and helpers for the core data router: target ids, mailbox
// addresses, the core request bundle and the address decode function.
package core_router_pkg;

   typedef enum logic [1:0] {
      TGT_PERIPH = 2'd0,
      TGT_STACK  = 2'd1,
      TGT_TCDM   = 2'd2,
      TGT_LOCAL  = 2'd3
   } tgt_id_e;

   localparam int          NUM_TGT        = 3;
   localparam logic [31:0] EXIT_ADDR_DFLT = 32'h8000_0000;
   localparam logic [31:0] PUTC_ADDR_DFLT = 32'h8000_0004;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } core_req_t;

   // Mailboxes win over everything, then the HWPE window bit, then the
   // low 16 MiB stack region; all other addresses go to TCDM.
   function automatic tgt_id_e decode_tgt(input logic [31:0] addr,
                                          input int          hwpe_bit,
                                          input logic [31:0] exit_addr,
                                          input logic [31:0] putc_addr);
      tgt_id_e id;
      if (addr == exit_addr || addr == putc_addr) id = TGT_LOCAL;
      else if (addr[hwpe_bit])                    id = TGT_PERIPH;
      else if (addr[31:24] == 8'h00)              id = TGT_STACK;
      else                                        id = TGT_TCDM;
      return id;
   endfunction

endpackage

// File: rtl/core_router_id_fifo.sv
// Small synchronous FIFO holding the target id of each granted request so
// responses can be matched back in issue order.
module core_router_id_fifo #(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic [1:0] data_i,
   input  logic       pop_i,
   output logic [1:0] head_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = IW + 1;

   logic [1:0]    mem_q [(1 << IW)];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q, fill;
   logic          do_push, do_pop;

   assign fill    = wr_ptr_q - rd_ptr_q;
   assign full_o  = (fill == PW'(DEPTH));
   assign empty_o = (fill == '0);
   assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

   // A push into a full FIFO is accepted only when the head leaves the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer and storage update; reset clears everything so head is never X.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < (1 << IW); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/core_data_router.sv
// Routes the core data port to periph / stack / tcdm targets, serves the
// exit and putc mailboxes locally, and returns responses in request order.
module core_data_router
   import core_router_pkg::*;
#(
   parameter int          HWPE_ADDR_BASE_BIT = 20,
   parameter int          MAX_OUTSTANDING    = 2,
   parameter logic [31:0] EXIT_ADDR          = EXIT_ADDR_DFLT,
   parameter logic [31:0] PUTC_ADDR          = PUTC_ADDR_DFLT
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   input  logic                    data_we_i,
   input  logic [3:0]              data_be_i,
   input  logic [31:0]             data_addr_i,
   input  logic [31:0]             data_wdata_i,
   output logic                    data_rvalid_o,
   output logic [31:0]             data_rdata_o,
   output logic                    data_err_o,
   output logic [NUM_TGT-1:0]      tgt_req_o,
   input  logic [NUM_TGT-1:0]      tgt_gnt_i,
   output logic [NUM_TGT-1:0][31:0] tgt_add_o,
   output logic [NUM_TGT-1:0]      tgt_wen_o,
   output logic [NUM_TGT-1:0][3:0] tgt_be_o,
   output logic [NUM_TGT-1:0][31:0] tgt_data_o,
   input  logic [NUM_TGT-1:0]      tgt_r_valid_i,
   input  logic [NUM_TGT-1:0][31:0] tgt_r_data_i,
   output logic                    exit_valid_o,
   output logic [31:0]             exit_code_o,
   output logic                    putc_valid_o,
   output logic [7:0]              putc_char_o,
   output logic                    order_err_o
);

   core_req_t  core_req;
   tgt_id_e    dec_id, last_id_q;
   logic [1:0] head_id;
   logic       fifo_full, fifo_empty, push, pop;
   logic       issue_ok, local_gnt, order_viol;
   logic       local_rd_err_q, putc_valid_q, exit_valid_q, order_err_q;
   logic [7:0] putc_char_q;
   logic [31:0] exit_code_q;

   assign core_req = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
   assign dec_id   = decode_tgt(core_req.addr, HWPE_ADDR_BASE_BIT, EXIT_ADDR, PUTC_ADDR);

   core_router_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (dec_id),
      .pop_i   (pop),
      .head_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Response steering: only the head target may answer; a local head answers
   // the cycle after its grant. Any other response is a protocol violation.
   always_comb begin
      pop           = 1'b0;
      data_rvalid_o = 1'b0;
      data_rdata_o  = '0;
      data_err_o    = 1'b0;
      order_viol    = 1'b0;
      if (!fifo_empty && head_id == TGT_LOCAL) begin
         pop           = 1'b1;
         data_rvalid_o = 1'b1;
         data_err_o    = local_rd_err_q;
      end
      for (int t = 0; t < NUM_TGT; t++) begin
         if (tgt_r_valid_i[t]) begin
            if (!fifo_empty && head_id == 2'(t)) begin
               pop           = 1'b1;
               data_rvalid_o = 1'b1;
               data_rdata_o  = tgt_r_data_i[t];
            end else begin
               order_viol = 1'b1;
            end
         end
      end
   end

   // Issue gate: room in the FIFO (a same-cycle pop counts) and no switch of
   // target while earlier responses are still pending.
   always_comb begin
      issue_ok   = (!fifo_full || pop) && (fifo_empty || dec_id == last_id_q);
      local_gnt  = issue_ok && data_req_i && dec_id == TGT_LOCAL;
      tgt_req_o  = '0;
      for (int t = 0; t < NUM_TGT; t++)
         tgt_req_o[t] = issue_ok && data_req_i && dec_id == tgt_id_e'(t);
      data_gnt_o = local_gnt | (|(tgt_req_o & tgt_gnt_i));
      push       = data_gnt_o;
   end

   // Per-target request fields; idle targets see all-zero buses.
   for (genvar t = 0; t < NUM_TGT; t++) begin : g_tgt
      if (t == int'(TGT_TCDM)) begin : g_tcdm
         assign tgt_add_o[t] = tgt_req_o[t] ? {8'b0, core_req.addr[23:0]} : '0;
      end else begin : g_full
         assign tgt_add_o[t] = tgt_req_o[t] ? core_req.addr : '0;
      end
      assign tgt_wen_o[t]  = tgt_req_o[t] & ~core_req.we;
      assign tgt_be_o[t]   = tgt_req_o[t] ? core_req.be : '0;
      assign tgt_data_o[t] = tgt_req_o[t] ? core_req.wdata : '0;
   end

   // Local mailbox state, last-issued target and the sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_id_q      <= TGT_PERIPH;
         local_rd_err_q <= 1'b0;
         putc_valid_q   <= 1'b0;
         putc_char_q    <= '0;
         exit_valid_q   <= 1'b0;
         exit_code_q    <= '0;
         order_err_q    <= 1'b0;
      end else begin
         if (push) last_id_q <= dec_id;
         local_rd_err_q <= local_gnt & ~core_req.we;
         putc_valid_q   <= local_gnt & core_req.we & (core_req.addr == PUTC_ADDR);
         if (local_gnt && core_req.we && core_req.addr == PUTC_ADDR)
            putc_char_q <= core_req.wdata[7:0];
         if (local_gnt && core_req.we && core_req.addr == EXIT_ADDR) begin
            exit_valid_q <= 1'b1;
            exit_code_q  <= core_req.wdata;
         end
         if (order_viol) order_err_q <= 1'b1;
      end
   end

   assign putc_valid_o = putc_valid_q;
   assign putc_char_o  = putc_char_q;
   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;
   assign order_err_o  = order_err_q;

endmodule

// File: tb/tb_core_data_router.sv
// Directed bench for core_data_router: drives after the rising edge,
// samples on the falling edge, compares against hand-computed values.
module tb_core_data_router;
   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              data_req_i, data_gnt_o, data_we_i;
   logic [3:0]        data_be_i;
   logic [31:0]       data_addr_i, data_wdata_i;
   logic              data_rvalid_o, data_err_o;
   logic [31:0]       data_rdata_o;
   logic [2:0]        tgt_req_o, tgt_gnt_i, tgt_wen_o, tgt_r_valid_i;
   logic [2:0][31:0]  tgt_add_o, tgt_data_o, tgt_r_data_i;
   logic [2:0][3:0]   tgt_be_o;
   logic              exit_valid_o, putc_valid_o, order_err_o;
   logic [31:0]       exit_code_o;
   logic [7:0]        putc_char_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   core_data_router dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .tgt_req_o(tgt_req_o), .tgt_gnt_i(tgt_gnt_i), .tgt_add_o(tgt_add_o),
      .tgt_wen_o(tgt_wen_o), .tgt_be_o(tgt_be_o), .tgt_data_o(tgt_data_o),
      .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_data_i(tgt_r_data_i),
      .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o),
      .putc_valid_o(putc_valid_o), .putc_char_o(putc_char_o),
      .order_err_o(order_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(posedge clk_i); #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_wdata_i = wd; data_be_i = 4'hF;
   endtask

   task automatic idle();
      data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
      tgt_gnt_i = '0; tgt_r_valid_i = '0; tgt_r_data_i = '0;
   endtask

   initial begin
      rst_ni = 1'b0;
      idle();
      // reset state
      smp();
      chk("rst_gnt", data_gnt_o, 0);
      chk("rst_rvalid", data_rvalid_o, 0);
      chk("rst_tgt_req", tgt_req_o, 0);
      chk("rst_tgt_add0", tgt_add_o[0], 0);
      chk("rst_exit", {exit_valid_o, exit_code_o[30:0]}, 0);
      chk("rst_putc", {putc_valid_o, putc_char_o}, 0);
      chk("rst_order_err", order_err_o, 0);
      nxt(); nxt();
      rst_ni = 1'b1;
      nxt();

      // periph read, one-cycle response
      req(0, 32'h0010_0040, 0); tgt_gnt_i = 3'b001;
      smp();
      chk("p_req", tgt_req_o, 3'b001);
      chk("p_gnt", data_gnt_o, 1);
      chk("p_add", tgt_add_o[0], 32'h0010_0040);
      chk("p_wen", tgt_wen_o, 3'b001);
      nxt();
      idle(); tgt_r_valid_i = 3'b001; tgt_r_data_i[0] = 32'hDEAD_BEEF;
      smp();
      chk("p_rvalid", data_rvalid_o, 1);
      chk("p_rdata", data_rdata_o, 32'hDEAD_BEEF);
      chk("p_err", data_err_o, 0);
      nxt();
      idle();
      smp();
      chk("p_rvalid_off", data_rvalid_o, 0);
      chk("p_order_err", order_err_o, 0);
      nxt();

      // stack reads filling the FIFO; third granted with the first pop
      req(0, 32'h0000_1000, 0); tgt_gnt_i = 3'b010;
      smp(); chk("s1_gnt", data_gnt_o, 1); chk("s1_req", tgt_req_o, 3'b010);
      nxt();
      data_addr_i = 32'h0000_1004;
      smp(); chk("s2_gnt", data_gnt_o, 1);
      nxt();
      data_addr_i = 32'h0000_1008;
      smp(); chk("s3_blocked_gnt", data_gnt_o, 0); chk("s3_blocked_req", tgt_req_o, 0);
      nxt();
      tgt_r_valid_i = 3'b010; tgt_r_data_i[1] = 32'h0000_0011;
      smp();
      chk("s3_gnt_on_pop", data_gnt_o, 1);
      chk("s1_rdata", data_rdata_o, 32'h11);
      chk("s1_rvalid", data_rvalid_o, 1);
      nxt();
      data_req_i = 1'b0; tgt_r_data_i[1] = 32'h0000_0022;
      smp(); chk("s2_rdata", data_rdata_o, 32'h22);
      nxt();
      tgt_r_data_i[1] = 32'h0000_0033;
      smp(); chk("s3_rdata", data_rdata_o, 32'h33);
      nxt();
      idle();

      // tcdm outstanding blocks a stack read
      req(0, 32'h1000_0100, 0); tgt_gnt_i = 3'b100;
      smp();
      chk("t_req", tgt_req_o, 3'b100);
      chk("t_add", tgt_add_o[2], 32'h0000_0100);
      nxt();
      req(0, 32'h0000_2000, 0); tgt_gnt_i = 3'b010;
      smp(); chk("ts_hold_req", tgt_req_o, 0); chk("ts_hold_gnt", data_gnt_o, 0);
      nxt();
      smp(); chk("ts_hold_req2", tgt_req_o, 0);
      nxt();
      tgt_r_valid_i = 3'b100; tgt_r_data_i[2] = 32'h0000_0055;
      smp(); chk("t_rdata", data_rdata_o, 32'h55); chk("t_rvalid", data_rvalid_o, 1);
      chk("ts_hold_req3", tgt_req_o, 0);
      nxt();
      tgt_r_valid_i = '0;
      smp(); chk("ts_req_free", tgt_req_o, 3'b010); chk("ts_gnt_free", data_gnt_o, 1);
      nxt();
      data_req_i = 1'b0; tgt_r_valid_i = 3'b010; tgt_r_data_i[1] = 32'h0000_0066;
      smp(); chk("ts_rdata", data_rdata_o, 32'h66);
      nxt();
      idle();

      // mailboxes
      req(1, 32'h8000_0004, 32'h0000_0041);
      smp(); chk("m1_gnt", data_gnt_o, 1); chk("m1_tgt_req", tgt_req_o, 0);
      nxt();
      data_wdata_i = 32'h0000_000A;
      smp();
      chk("m1_rvalid", data_rvalid_o, 1); chk("m1_err", data_err_o, 0);
      chk("m1_putc", {putc_valid_o, putc_char_o}, 9'h141);
      chk("m2_gnt", data_gnt_o, 1);
      nxt();
      data_addr_i = 32'h8000_0000; data_wdata_i = 32'h0;
      smp();
      chk("m2_rvalid", data_rvalid_o, 1);
      chk("m2_putc", {putc_valid_o, putc_char_o}, 9'h10A);
      chk("m3_gnt", data_gnt_o, 1);
      chk("m3_exit_pre", exit_valid_o, 0);
      nxt();
      data_req_i = 1'b0;
      smp();
      chk("m3_rvalid", data_rvalid_o, 1);
      chk("m3_putc_off", putc_valid_o, 0);
      chk("m3_exit", {exit_valid_o, exit_code_o[30:0]}, 32'h8000_0000);
      nxt();
      req(1, 32'h8000_0000, 32'h0000_002A);
      smp(); chk("m4_rvalid_idle", data_rvalid_o, 0);
      nxt();
      req(0, 32'h8000_0004, 0);
      smp();
      chk("m4_exit_code", exit_code_o, 32'h2A);
      chk("m5_gnt", data_gnt_o, 1);
      nxt();
      idle();
      smp();
      chk("m5_rvalid", data_rvalid_o, 1);
      chk("m5_err", data_err_o, 1);
      chk("m5_rdata", data_rdata_o, 0);
      chk("m5_putc_off", putc_valid_o, 0);
      nxt();

      // stray response with empty FIFO
      tgt_r_valid_i = 3'b010; tgt_r_data_i[1] = 32'h1234_5678;
      smp(); chk("o_rvalid", data_rvalid_o, 0); chk("o_err_pre", order_err_o, 0);
      nxt();
      idle();
      smp(); chk("o_err", order_err_o, 1);
      nxt(); nxt();
      smp(); chk("o_err_sticky", order_err_o, 1);
      chk("exit_sticky", exit_valid_o, 1);
      nxt();

      // reset with a tcdm read outstanding
      req(0, 32'h2000_0000, 0); tgt_gnt_i = 3'b100;
      smp(); chk("r_t_gnt", data_gnt_o, 1);
      nxt();
      idle();
      rst_ni = 1'b0;
      #1;
      chk("r_order_err", order_err_o, 0);
      chk("r_exit", {exit_valid_o, exit_code_o[30:0]}, 0);
      chk("r_rvalid", data_rvalid_o, 0);
      nxt();
      rst_ni = 1'b1;
      req(0, 32'h0000_0100, 0); tgt_gnt_i = 3'b010;
      smp(); chk("r_s_gnt", data_gnt_o, 1); chk("r_s_req", tgt_req_o, 3'b010);
      nxt();
      idle(); tgt_r_valid_i = 3'b010; tgt_r_data_i[1] = 32'h0000_0077;
      smp(); chk("r_s_rdata", data_rdata_o, 32'h77);
      nxt();
      idle();
      smp(); chk("r_err_clean", order_err_o, 0);
      nxt();
      tgt_r_valid_i = 3'b100; tgt_r_data_i[2] = 32'hBAD0_0000;
      smp(); chk("r_late_rvalid", data_rvalid_o, 0);
      nxt();
      idle();
      smp(); chk("r_late_err", order_err_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_data_router.md
# core_data_router

Routes the zeroriscy data port of the HWPE test system to its three targets (HWPE peripheral port, stack memory, TCDM memory). It also terminates the end-of-test mailbox locally. Outstanding transactions are tracked in a small ID FIFO so every response is steered back to the core in request order. The router sits between the core's data interface and the accelerator/memory ports, replacing ad-hoc combinational response muxing.

## Interface
Parameters:
- HWPE_ADDR_BASE_BIT, 20, address bit selecting the HWPE peripheral port
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (power of two, ≥1)
- EXIT_ADDR, 32'h8000_0000, exit-code mailbox address
- PUTC_ADDR, 32'h8000_0004, character-output mailbox address

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i / data_gnt_o  in/out  1  core request / grant
- data_we_i  in  1  core write enable (1 = write)
- data_be_i  in  4  byte enables
- data_addr_i / data_wdata_i  in  32  address / write data
- data_rvalid_o / data_rdata_o  out  1/32  response to core
- data_err_o  out  1  error, valid with data_rvalid_o
- tgt_req_o  out  3  per-target request; index 0 periph, 1 stack, 2 tcdm
- tgt_gnt_i  in  3  per-target grant
- tgt_add_o  out  3x32  address; tcdm index carries {8'b0, addr[23:0]}, others carry the full address
- tgt_wen_o  out  3  active-low write enable (1 = read)
- tgt_be_o / tgt_data_o  out  3x4 / 3x32  byte enables / write data
- tgt_r_valid_i / tgt_r_data_i  in  3 / 3x32  per-target responses
- exit_valid_o / exit_code_o  out  1/32  exit code written (sticky)
- putc_valid_o / putc_char_o  out  1/8  one-cycle character strobe
- order_err_o  out  1  sticky protocol-violation flag

## Operation
- Decode, evaluated in this order:
  - address == EXIT_ADDR or PUTC_ADDR: local target (id 3)
  - addr[HWPE_ADDR_BASE_BIT]: periph
  - addr[31:24] == 0: stack
  - otherwise: tcdm
- Request issue is permitted only when both hold:
  - the FIFO is not full
  - the FIFO is empty, or the decoded id equals the id of the last pushed entry (no cross-target reordering)
- If issue is not permitted: all tgt_req_o = 0 and data_gnt_o = 0. The core holds its request.
- Forwarded request: tgt_req_o[id] = data_req_i; data_gnt_o = tgt_gnt_i[id]. A grant pushes id into the FIFO.
- Local request: granted in the same cycle. The id is pushed.
  - Write to EXIT_ADDR: latch data_wdata_i into exit_code_o and set exit_valid_o.
  - Write to PUTC_ADDR: pulse putc_valid_o with putc_char_o = wdata[7:0].
  - Read from either address: rdata = 0 with data_err_o = 1.
- Response path:
  - tgt_r_valid_i[head] pops the FIFO and drives data_rvalid_o, data_rdata_o and data_err_o = 0 combinationally.
  - A local head responds one cycle after its grant.
- tgt_r_valid_i on a non-head target, or any r_valid with an empty FIFO: set order_err_o. The response is dropped and nothing is popped.
- A pop and a push in the same cycle are allowed when the FIFO is full: the pop frees the slot.

## Timing
- Request path is combinational (zero added latency). Response path is combinational from tgt_r_valid_i.
- Local target: grant in cycle N, rvalid in cycle N+1.
- Reset values:
  - all outputs 0
  - FIFO empty; exit_code_o = 0; order_err_o = 0
- exit_valid_o and order_err_o stay high until reset.
- Reset asserted mid-transaction discards all outstanding entries. Late target responses after reset set order_err_o.

## Structure
- Package core_router_pkg holds:
  - target id typedef (2-bit enum PERIPH, STACK, TCDM, LOCAL)
  - mailbox address constants
  - the decode function
- Sub-module core_router_id_fifo: synchronous FIFO, DEPTH = MAX_OUTSTANDING, 2-bit entries, with full/empty/head outputs. Pointers are one bit wider than needed for wrap detection.

## Test plan
- Read from 0x0010_0040 (bit 20 set), periph grants immediately and responds one cycle later with 0xDEADBEEF -> tgt_req_o = 3'b001, core sees rdata 0xDEADBEEF, order_err_o = 0.
- Two back-to-back stack reads with MAX_OUTSTANDING = 2 and a third issued before any response -> third is not granted until the first rvalid arrives. Then it is granted in the same cycle as the pop.
- A tcdm read is outstanding, then a stack read is issued -> stack req held at 0 until the tcdm response is returned.
- Write 0x41 then 0x0A to 0x8000_0004, then write 0 to 0x8000_0000 -> two putc strobes with chars 0x41 and 0x0A, exit_valid_o = 1, exit_code_o = 0, each write acknowledged with rvalid one cycle after its grant.
- Inject tgt_r_valid_i[1] with the FIFO empty -> order_err_o = 1 and stays set, data_rvalid_o = 0.
- Deassert rst_ni with one tcdm read outstanding -> outputs return to 0 and the FIFO is empty. After release, a new stack read is granted immediately.
